// File: rtl/snake_tick_scheduler.sv
// Game-step scheduler: clock-enable prescaler, speed-level period control and
// step_req/step_ack handshake with run, pause and game-over sequencing.
module snake_tick_scheduler #(
  parameter int PRESCALE        = 100000,
  parameter int BASE_PERIOD     = 250,
  parameter int STEP_DEC        = 20,
  parameter int MIN_PERIOD      = 50,
  parameter int FOODS_PER_LEVEL = 4,
  parameter int MAX_LEVEL       = 10
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic       pause_btn,
  input  logic       game_over,
  input  logic       food_eaten,
  input  logic       step_ack,
  output logic       step_req,
  output logic [3:0] level,
  output logic [7:0] period,
  output logic [2:0] state,
  output logic       overrun
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    WAIT_ACK = 3'd2,
    PAUSED   = 3'd3,
    OVER     = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     ms_cnt_q, ms_cnt_d;
  logic [FW-1:0]  food_cnt_q, food_cnt_d;
  logic [3:0]     level_q, level_d;
  logic [7:0]     period_q, period_d;
  logic           step_req_q, step_req_d;
  logic           overrun_q, overrun_d;
  logic           pause_pend_q, pause_pend_d;

  logic           running, tick, elapse, advance;
  logic signed [31:0] period_calc;

  assign running = (state_q == RUN) || (state_q == WAIT_ACK);
  assign tick    = running && (presc_q == PW'(PRESCALE - 1));
  // >= rather than == so a period that shrinks mid-interval still fires
  assign elapse  = tick && (ms_cnt_q >= (period_q - 8'd1));

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    ms_cnt_d     = ms_cnt_q;
    food_cnt_d   = food_cnt_q;
    level_d      = level_q;
    step_req_d   = step_req_q;
    overrun_d    = overrun_q;
    pause_pend_d = pause_pend_q;
    advance      = 1'b0;

    period_calc = BASE_PERIOD - $signed({28'd0, level_q}) * STEP_DEC;
    period_d    = (period_calc < MIN_PERIOD) ? 8'(MIN_PERIOD) : 8'(period_calc);

    if (game_over && (running || state_q == PAUSED)) begin
      state_d    = OVER;
      step_req_d = 1'b0;
    end else if (start) begin
      state_d      = RUN;
      presc_d      = '0;
      ms_cnt_d     = '0;
      food_cnt_d   = '0;
      level_d      = '0;
      overrun_d    = 1'b0;
      pause_pend_d = 1'b0;
      step_req_d   = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (pause_btn) begin
            state_d = PAUSED;
          end else begin
            advance = 1'b1;
            if (elapse) begin
              state_d    = WAIT_ACK;
              step_req_d = 1'b1;
            end
          end
        end
        WAIT_ACK: begin
          advance = 1'b1;
          if (step_ack) begin
            if (elapse) begin
              step_req_d   = 1'b1;
              pause_pend_d = pause_pend_q | pause_btn;
            end else begin
              step_req_d   = 1'b0;
              state_d      = (pause_pend_q || pause_btn) ? PAUSED : RUN;
              pause_pend_d = 1'b0;
            end
          end else begin
            if (elapse) overrun_d = 1'b1;
            if (pause_btn) pause_pend_d = 1'b1;
          end
        end
        PAUSED: begin
          if (pause_btn) state_d = RUN;
        end
        default: ;
      endcase

      if (advance) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) ms_cnt_d = elapse ? 8'd0 : ms_cnt_q + 8'd1;
      end

      if (running && food_eaten) begin
        if (food_cnt_q == FW'(FOODS_PER_LEVEL - 1)) begin
          food_cnt_d = '0;
          if (level_q < 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
        end else begin
          food_cnt_d = food_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      ms_cnt_q     <= '0;
      food_cnt_q   <= '0;
      level_q      <= '0;
      period_q     <= 8'(BASE_PERIOD);
      step_req_q   <= 1'b0;
      overrun_q    <= 1'b0;
      pause_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      ms_cnt_q     <= ms_cnt_d;
      food_cnt_q   <= food_cnt_d;
      level_q      <= level_d;
      period_q     <= period_d;
      step_req_q   <= step_req_d;
      overrun_q    <= overrun_d;
      pause_pend_q <= pause_pend_d;
    end
  end

  assign step_req = step_req_q;
  assign level    = level_q;
  assign period   = period_q;
  assign state    = state_q;
  assign overrun  = overrun_q;

endmodule
